clk_freq_meter: RTL

//  Measures a clock-like signal (e.g. divided/multiplied clock from the clock generator) sampled in the i_clk domain.

---
 rtl/clk_freq_meter_pkg.sv | 13 +
 rtl/clk_freq_meter_sync_edge_det.sv | 30 +++
 rtl/clk_freq_meter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/clk_freq_meter_pkg.sv
// Shared types for the clock frequency meter and the clock BIST logic that
// decodes its state encoding.
package clk_freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_EDGE = 2'd1,
        ST_MEASURE   = 2'd2
    } meter_state_e;

    localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_freq_meter_sync_edge_det.sv
// Brings the monitored signal into the i_clk domain and flags its rising edge.
module clk_freq_meter_sync_edge_det
    import clk_freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_s,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], i_async};
            s_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign o_s    = sync_q[SYNC_STAGES-1];
    assign o_rise = sync_q[SYNC_STAGES-1] & ~s_prev_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Measures period and high time of a monitored clock in i_clk cycles, with
// lock detection against an expected period and a no-edge timeout.
module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_clk_mon,
    input  logic [CNT_WIDTH-1:0] i_exp_period,
    input  logic [CNT_WIDTH-1:0] i_tol,
    output logic [CNT_WIDTH-1:0] o_period,
    output logic [CNT_WIDTH-1:0] o_high,
    output logic                 o_valid,
    output logic                 o_locked,
    output logic                 o_timeout
);

    localparam int                   LC_W     = $clog2(LOCK_COUNT + 1);
    localparam logic [LC_W-1:0]      LOCK_MAX = LC_W'(LOCK_COUNT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(TIMEOUT - 1);

    meter_state_e         state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, high_cnt_q, high_cnt_d;
    logic [CNT_WIDTH-1:0] period_q, period_d, high_q, high_d;
    logic [LC_W-1:0]      lock_cnt_q, lock_cnt_d;
    logic                 valid_q, valid_d, locked_q, locked_d, timeout_q, timeout_d;

    logic                 s, rise;
    logic [CNT_WIDTH-1:0] cnt_inc, high_cnt_inc;
    logic [CNT_WIDTH:0]   diff, abs_diff;
    logic                 in_tol;

    clk_freq_meter_sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_clk_mon),
        .o_s     (s),
        .o_rise  (rise)
    );

    assign cnt_inc      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign high_cnt_inc = (high_cnt_q == CNT_MAX) ? high_cnt_q : high_cnt_q + 1'b1;

    // One extra bit keeps the sign so |a-b| never wraps for any pair of inputs.
    assign diff     = {1'b0, cnt_q} - {1'b0, i_exp_period};
    assign abs_diff = diff[CNT_WIDTH] ? (~diff + 1'b1) : diff;
    assign in_tol   = (abs_diff <= {1'b0, i_tol});

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_cnt_d = high_cnt_q;
        lock_cnt_d = lock_cnt_q;
        period_d   = period_q;
        high_d     = high_q;
        locked_d   = locked_q;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                high_cnt_d = '0;
                lock_cnt_d = '0;
                locked_d   = 1'b0;
                if (i_en) state_d = ST_WAIT_EDGE;
            end
            ST_WAIT_EDGE: begin
                // The first edge only opens a window; the partial period is discarded.
                if (rise) begin
                    state_d    = ST_MEASURE;
                    cnt_d      = CNT_WIDTH'(1);
                    high_cnt_d = CNT_WIDTH'(1);
                end else if (cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_MEASURE: begin
                if (lock_cnt_q == LOCK_MAX) locked_d = 1'b1;
                if (rise) begin
                    period_d   = cnt_q;
                    high_d     = high_cnt_q;
                    valid_d    = 1'b1;
                    cnt_d      = CNT_WIDTH'(1);
                    high_cnt_d = CNT_WIDTH'(1);
                    if (in_tol) begin
                        if (lock_cnt_q != LOCK_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
                    end else begin
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                    end
                end else if (cnt_q == TO_LAST) begin
                    timeout_d  = 1'b1;
                    locked_d   = 1'b0;
                    lock_cnt_d = '0;
                    cnt_d      = '0;
                    high_cnt_d = '0;
                    state_d    = ST_WAIT_EDGE;
                end else begin
                    cnt_d = cnt_inc;
                    if (s) high_cnt_d = high_cnt_inc;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!i_en) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            high_cnt_d = '0;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            valid_d    = 1'b0;
            timeout_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            high_cnt_q <= '0;
            lock_cnt_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_cnt_q <= high_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_period  = period_q;
    assign o_high    = high_q;
    assign o_valid   = valid_q;
    assign o_locked  = locked_q;
    assign o_timeout = timeout_q;

endmodule
